// File: rtl/npu_conv_pkg.sv
// rtl/npu_conv_pkg.sv - shared constants, scheduler states and conv_w packing helper
package npu_conv_pkg;

  localparam int K_H       = 3;
  localparam int K_W       = 3;
  localparam int K_N       = K_H * K_W;
  localparam int MAX_H     = 16;
  localparam int MAX_W     = 15;
  localparam int CW_BITS   = 8 * K_N;
  localparam int WLOAD_CYC = K_N + 2;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CHECK,
    S_LOADW,
    S_TRIG,
    S_WPIX,
    S_WRITE,
    S_ACK,
    S_NEXTCH,
    S_FIN
  } sched_state_t;

  // Replace byte k of a row-major packed kernel, byte 0 in the LSBs.
  function automatic logic [CW_BITS-1:0] conv_w_set(input logic [CW_BITS-1:0] cw,
                                                    input logic [3:0]         k,
                                                    input logic [7:0]         d);
    logic [CW_BITS-1:0] r;
    r = cw;
    for (int i = 0; i < K_N; i++) begin
      if (k == 4'(i)) r[8*i +: 8] = d;
    end
    return r;
  endfunction

endpackage

// File: rtl/conv_wload.sv
// rtl/conv_wload.sv - 9-read weight fetch counter and kernel register file
module conv_wload
  import npu_conv_pkg::*;
#(
  parameter int W_AW = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_en,
  input  logic [W_AW-1:0]    i_base,
  output logic               o_rd_en,
  output logic [W_AW-1:0]    o_rd_addr,
  input  logic [7:0]         i_rd_data,
  output logic [CW_BITS-1:0] o_conv_w,
  output logic               o_last
);

  logic [3:0]         r_cnt;
  logic               r_wr_vld;
  logic [3:0]         r_wr_k;
  logic [CW_BITS-1:0] r_w;

  assign o_rd_en   = i_en && (32'(r_cnt) < K_N);
  assign o_rd_addr = o_rd_en ? (i_base + W_AW'(r_cnt)) : '0;
  assign o_last    = i_en && (32'(r_cnt) == WLOAD_CYC - 1);
  assign o_conv_w  = r_w;

  // Read data arrives one cycle after the strobe, so the write trails the read by one.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt    <= '0;
      r_wr_vld <= 1'b0;
      r_wr_k   <= '0;
      r_w      <= '0;
    end else begin
      r_cnt    <= (i_en && !o_last) ? r_cnt + 4'd1 : 4'd0;
      r_wr_vld <= o_rd_en;
      r_wr_k   <= r_cnt;
      if (r_wr_vld) r_w <= conv_w_set(r_w, r_wr_k, i_rd_data);
    end
  end

endmodule

// File: rtl/conv_layer_sched.sv
// rtl/conv_layer_sched.sv - per-channel weight load, conv trigger and pixel store sequencer
module conv_layer_sched
  import npu_conv_pkg::*;
#(
  parameter int NUM_CH     = 10,
  parameter int PIX_STRIDE = 256,
  parameter int L2_WBASE   = 90,
  parameter int W_AW       = 8,
  parameter int O_AW       = 12
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic               i_layer_sel,
  input  logic [4:0]         i_cfg_w,
  input  logic [4:0]         i_cfg_h,
  input  logic [3:0]         i_cfg_nch,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_cfg_err,
  output logic               o_conv_trigger,
  output logic               o_conv_save_done,
  output logic [3:0]         o_conv_chan,
  output logic               o_conv_layer,
  output logic [CW_BITS-1:0] o_conv_w,
  input  logic               i_conv_valid,
  input  logic               i_conv_done,
  input  logic [23:0]        i_conv_pixel,
  input  logic [7:0]         i_conv_addr,
  output logic               o_w_rd_en,
  output logic [W_AW-1:0]    o_w_rd_addr,
  input  logic [7:0]         i_w_rd_data,
  output logic               o_obuf_we,
  output logic [O_AW-1:0]    o_obuf_addr,
  output logic [23:0]        o_obuf_data,
  input  logic               i_obuf_ready
);

  sched_state_t r_state, w_next;
  logic         r_layer;
  logic [4:0]   r_cfg_w, r_cfg_h;
  logic [3:0]   r_nch, r_chan;
  logic         r_err;
  logic [23:0]  r_pixel;
  logic [7:0]   r_paddr;
  logic         r_pdone;

  logic            w_illegal, w_last_ch, w_wl_last;
  logic [W_AW-1:0] w_wbase;
  logic [O_AW-1:0] w_obase;

  assign w_illegal = (32'(r_cfg_w) < K_W) || (32'(r_cfg_h) < K_H) ||
                     (32'(r_cfg_w) > MAX_W) || (32'(r_cfg_h) > MAX_H) ||
                     (r_nch == 4'd0) || (32'(r_nch) > NUM_CH);
  assign w_last_ch = (r_chan + 4'd1) == r_nch;

  // Both products are unsigned and wrap to the address width.
  assign w_wbase = (r_layer ? W_AW'(L2_WBASE) : '0) + W_AW'(32'(r_chan) * K_N);
  assign w_obase = O_AW'(32'(r_chan) * PIX_STRIDE);

  assign o_busy       = (r_state != S_IDLE) && (r_state != S_FIN);
  assign o_conv_chan  = r_chan;
  assign o_conv_layer = r_layer;
  assign o_obuf_addr  = w_obase + O_AW'(r_paddr);
  assign o_obuf_data  = r_pixel;

  conv_wload #(.W_AW(W_AW)) u_wload (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_en      (r_state == S_LOADW),
    .i_base    (w_wbase),
    .o_rd_en   (o_w_rd_en),
    .o_rd_addr (o_w_rd_addr),
    .i_rd_data (i_w_rd_data),
    .o_conv_w  (o_conv_w),
    .o_last    (w_wl_last)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_layer <= 1'b0;
      r_cfg_w <= '0;
      r_cfg_h <= '0;
      r_nch   <= '0;
      r_chan  <= '0;
      r_err   <= 1'b0;
      r_pixel <= '0;
      r_paddr <= '0;
      r_pdone <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: if (i_start) begin
          r_layer <= i_layer_sel;
          r_cfg_w <= i_cfg_w;
          r_cfg_h <= i_cfg_h;
          r_nch   <= i_cfg_nch;
        end
        S_CHECK: begin
          r_err  <= w_illegal;
          r_chan <= '0;
        end
        S_WPIX: if (i_conv_valid) begin
          r_pixel <= i_conv_pixel;
          r_paddr <= i_conv_addr;
          r_pdone <= i_conv_done;
        end
        S_NEXTCH: if (!w_last_ch) r_chan <= r_chan + 4'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next           = r_state;
    o_conv_trigger   = 1'b0;
    o_conv_save_done = 1'b0;
    o_obuf_we        = 1'b0;
    o_done           = 1'b0;
    o_cfg_err        = 1'b0;
    case (r_state)
      S_IDLE:   if (i_start) w_next = S_CHECK;
      S_CHECK:  w_next = w_illegal ? S_FIN : S_LOADW;
      S_LOADW:  if (w_wl_last) w_next = S_TRIG;
      S_TRIG: begin
        o_conv_trigger = 1'b1;
        w_next         = S_WPIX;
      end
      S_WPIX:   if (i_conv_valid) w_next = S_WRITE;
      S_WRITE: begin
        o_obuf_we = 1'b1;
        // The last pixel needs no save_done: conv has already finished.
        if (i_obuf_ready) w_next = r_pdone ? S_NEXTCH : S_ACK;
      end
      S_ACK: begin
        o_conv_save_done = 1'b1;
        w_next           = S_WPIX;
      end
      S_NEXTCH: w_next = w_last_ch ? S_FIN : S_LOADW;
      S_FIN: begin
        o_done    = 1'b1;
        o_cfg_err = r_err;
        w_next    = S_IDLE;
      end
      default:  w_next = S_IDLE;
    endcase
  end

endmodule
